spi_tx: RTL and testbench
=========================

# spi_tx

Byte-to-serial transmitter that is the upstream partner of `spi_rx`. It accepts bytes on a parallel write port into a small FIFO and shifts each byte out MSB first, one bit per rising `clk` edge. It drives a `flush` output that is asserted whenever no valid bit is on the line, so that `spi_tx.bit`/`spi_tx.flush` can connect directly to `spi_rx.bit`/`spi_rx.flush` on the same `clk`, and `spi_rx.byte` reproduces every byte written.

## Interface
- `DEPTH`, 4: FIFO capacity in bytes. Must be a power of 2 and at least 2.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `data_in` input 8: byte to enqueue.
- `wr` input 1: write strobe, sampled on the rising edge.
- `abort` input 1: active-high. Drops the byte currently being shifted.
- `bit` output 1: serial data, registered, MSB first.
- `flush` output 1: registered. 1 = line idle or invalid; 0 = `bit` carries a valid data bit.
- `busy` output 1: 1 while in SHIFT.
- `full` output 1: FIFO holds `DEPTH` bytes.
- `empty` output 1: FIFO holds 0 bytes.
- `ovf` output 1: sticky overflow flag; cleared only by `rst`.

## Operation
- FIFO: circular buffer with `DEPTH` entries, read/write pointers of log2(`DEPTH`) bits that wrap, and an occupancy count of log2(`DEPTH`)+1 bits.
  - `full` = (count == `DEPTH`); `empty` = (count == 0). Both are registered-state derived.
- Write: at an edge with `wr`=1 and `full`=0, `data_in` is stored.
  - With `wr`=1 and `full`=1 the byte is dropped and `ovf` is set to 1.
  - `full` is judged on the pre-edge state. A write while full is rejected even if a pop happens at the same edge.
- FSM states:
  - IDLE: `flush`=1, `bit`=0, `busy`=0.
  - SHIFT: `flush`=0, `busy`=1. Holds an 8-bit shift register and a 3-bit counter `cnt`.
- IDLE -> SHIFT: at an edge where `empty`=0 and `abort`=0.
  - Pop the FIFO head into the shift register.
  - Drive `bit` = head[7] and `flush`=0.
  - Set `cnt`=0.
- In SHIFT, each edge with `abort`=0 and `cnt`<7: `bit` takes the next lower bit and `cnt` increments.
- At the edge with `cnt`==7, the last bit (bit0) has been on the line for one cycle. Then:
  - if FIFO is non-empty: pop the next byte immediately, `bit` = new[7], `cnt`=0, and `flush` stays 0 (back-to-back, no gap);
  - otherwise go to IDLE (`flush`=1, `bit`=0).
- Abort: at any edge with `abort`=1 in SHIFT:
  - go to IDLE, `flush`=1, `bit`=0;
  - the current byte is lost; FIFO contents are kept;
  - no pop happens on that edge.
  - If `abort` is held, the FSM stays in IDLE. Shifting resumes at the first edge with `abort`=0 and FIFO non-empty.
- Simultaneous write and pop in the same edge: count is unchanged, and both pointers advance.

## Timing
- Reset values: `bit`=0, `flush`=1, `busy`=0, `empty`=1, `full`=0, `ovf`=0. Pointers, count and `cnt` = 0. FSM = IDLE.
- `rst` has priority over `wr`/`abort`. If asserted mid-byte, the byte and all queued bytes are discarded at that edge.
- Latency, write at edge k into an empty FIFO while IDLE:
  - pop at edge k+1, so bit7 is valid after edge k+1;
  - bit0 is valid after edge k+8;
  - `spi_rx` samples bits at edges k+2..k+9, so `spi_rx.byte` updates after edge k+9.
- Throughput: 8 cycles per byte, sustained with no idle cycle while the FIFO is non-empty.
- The `flush` deassert and assert edges coincide exactly with the first and last valid bit. `spi_rx` therefore never counts idle bits.

## Test plan
- Write 8'hCA after reset:
  - `bit` sequence 1,1,0,0,1,0,1,0 on 8 consecutive cycles with `flush`=0;
  - then `flush`=1 and `busy`=0;
  - the loopback `spi_rx.byte` becomes 8'hCA.
- Write 8'hCA then 8'h3F on consecutive edges:
  - 16 valid bits with no `flush` gap;
  - the receiver shows 8'hCA, then 8'h3F exactly 8 cycles later.
- With `DEPTH`=4, write 6 bytes back-to-back from reset:
  - the first byte is popped at the second write's edge;
  - the 6th write is rejected and `ovf`=1 (it stays 1 until `rst`);
  - exactly 5 bytes are transmitted, in order.
- Write 8'hA7 and 8'h55, then assert `abort` for 1 cycle after 3 bits of 8'hA7:
  - `flush`=1 for one cycle;
  - then 8'h55 is shifted out;
  - the receiver never shows 8'hA7.
- Assert `rst` mid-byte with 2 bytes queued:
  - all outputs return to their reset values on the next edge;
  - nothing is transmitted afterwards.
- Write 4 bytes to fill the FIFO while IDLE, then write again on the pop edge:
  - the write is rejected;
  - `ovf`=1 and `full` clears next cycle.

Source files
------------

// File: rtl/spi_tx.sv
// Byte-to-serial transmitter: small circular FIFO feeding an MSB-first shifter.
// The flush/ser_bit pair is framed so a same-clock spi_rx receives every byte.
module spi_tx #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       wr,
    input  logic       abort,
    output logic       ser_bit,
    output logic       flush,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       ovf
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nx;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    sreg;
    logic [2:0]    cnt;
    logic [7:0]    head;
    logic          push, pop, shift;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr && !full;
    assign head  = mem[rd_ptr];
    assign busy  = (state == SHIFT);
    // flush is the decode of the registered state bit, so it is glitch-free
    assign flush = !busy;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        shift    = 1'b0;
        case (state)
            IDLE: begin
                if (!abort && !empty) begin
                    pop      = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (abort)
                    state_nx = IDLE;
                else if (cnt != 3'd7)
                    shift = 1'b1;
                else if (!empty)
                    pop = 1'b1;       // back-to-back: next byte follows bit0 with no gap
                else
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            sreg    <= '0;
            cnt     <= '0;
            ser_bit <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state <= state_nx;
            if (wr && full)
                ovf <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                sreg    <= head;
                ser_bit <= head[7];
                cnt     <= '0;
            end else if (shift) begin
                sreg    <= {sreg[6:0], 1'b0};
                ser_bit <= sreg[6];
                cnt     <= cnt + 3'd1;
            end else if (state_nx == IDLE) begin
                ser_bit <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_tx.sv
// Bench for spi_tx: queue-level transmitter model plus a loopback receiver on the line.
module tb_spi_tx;
    localparam int DEPTH = 4;

    logic       clk, rst, wr, abort;
    logic [7:0] data_in;
    logic       ser_bit, flush, busy, full, empty, ovf;

    spi_tx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr(wr), .abort(abort),
        .ser_bit(ser_bit), .flush(flush), .busy(busy), .full(full),
        .empty(empty), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // model state: bytes accepted but not yet started, and the byte on the line
    logic [7:0] q[$];
    logic [7:0] m_cur = 8'h00;
    int         m_idx = 0;
    logic       m_active = 1'b0;
    logic       m_ovf = 1'b0;
    logic       armed = 1'b0;
    int         cyc = 0;
    int         wr_cyc = 0;

    // loopback receiver, sampling the line like spi_rx on the same edge
    logic [7:0] rsh = 8'h00;
    int         rcnt = 0;
    logic [7:0] rxq[$];
    int         rxc[$];
    logic [7:0] ex[$];

    always @(posedge clk) begin
        logic full_pre;
        cyc++;
        if (armed) begin
            if (flush) rcnt = 0;
            else begin
                rsh = {rsh[6:0], ser_bit};
                rcnt++;
                if (rcnt == 8) begin
                    rxq.push_back(rsh);
                    rxc.push_back(cyc);
                    rcnt = 0;
                end
            end
        end
        if (rst) begin
            q.delete();
            m_active = 1'b0;
            m_idx = 0;
            m_ovf = 1'b0;
            armed = 1'b1;
        end else begin
            full_pre = (q.size() == DEPTH);
            if (m_active && abort) m_active = 1'b0;
            else if (m_active && m_idx > 0) m_idx--;
            else if (!abort && q.size() > 0) begin
                m_cur = q.pop_front();
                m_idx = 7;
                m_active = 1'b1;
            end else m_active = 1'b0;
            if (wr) begin
                wr_cyc = cyc;
                if (full_pre) m_ovf = 1'b1;
                else q.push_back(data_in);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("flush", flush, !m_active);
            check("busy", busy, m_active);
            check("bit", ser_bit, m_active ? m_cur[m_idx] : 1'b0);
            check("empty", empty, q.size() == 0);
            check("full", full, q.size() == DEPTH);
            check("ovf", ovf, m_ovf);
        end
    end

    task automatic do_reset();
        rst = 1'b1; wr = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rxq.delete();
        rxc.delete();
    endtask

    task automatic write(input logic [7:0] d);
        wr = 1'b1; data_in = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_rx(input string name);
        check({name, "_count"}, rxq.size(), ex.size());
        for (int i = 0; i < ex.size(); i++)
            check(name, (i < rxq.size()) ? {24'h0, rxq[i]} : 32'hdead, ex[i]);
        ex.delete();
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; abort = 1'b0; data_in = 8'h00;
        do_reset();
        check("rst_flush", flush, 1'b1);
        check("rst_bit", ser_bit, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_ovf", ovf, 1'b0);

        // single byte, latency write edge -> receiver byte is 9 edges
        write(8'hCA);
        idle(12);
        ex.push_back(8'hCA);
        check_rx("ca");
        check("ca_latency", (rxc.size() > 0) ? rxc[0] - wr_cyc : -1, 9);
        check("ca_busy_end", busy, 1'b0);
        check("ca_flush_end", flush, 1'b1);

        // back-to-back bytes, 8 cycles apart at the receiver
        do_reset();
        write(8'hCA);
        write(8'h3F);
        idle(20);
        ex.push_back(8'hCA); ex.push_back(8'h3F);
        check_rx("b2b");
        check("b2b_spacing", (rxc.size() > 1) ? rxc[1] - rxc[0] : -1, 8);

        // six writes: first pops immediately, sixth overflows
        do_reset();
        for (int i = 1; i <= 6; i++) write(8'(i * 8'h11));
        check("ovf_set", ovf, 1'b1);
        idle(50);
        for (int i = 1; i <= 5; i++) ex.push_back(8'(i * 8'h11));
        check_rx("six");
        check("ovf_sticky", ovf, 1'b1);
        do_reset();
        check("ovf_cleared", ovf, 1'b0);

        // abort after 3 bits of A7
        write(8'hA7);
        write(8'h55);
        idle(2);
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        check("abort_flush", flush, 1'b1);
        idle(20);
        ex.push_back(8'h55);
        check_rx("abort");

        // reset mid-byte with bytes queued
        do_reset();
        write(8'h01); write(8'h02); write(8'h03);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_flush", flush, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_empty", empty, 1'b1);
        check("midrst_full", full, 1'b0);
        idle(30);
        check_rx("midrst");

        // fill while held idle, then write on the pop edge
        do_reset();
        abort = 1'b1;
        write(8'hC1); write(8'hC2); write(8'hC3); write(8'hC4);
        check("fill_full", full, 1'b1);
        abort = 1'b0;
        write(8'hEE);
        check("fill_ovf", ovf, 1'b1);
        check("fill_full_clr", full, 1'b0);
        idle(40);
        ex.push_back(8'hC1); ex.push_back(8'hC2); ex.push_back(8'hC3); ex.push_back(8'hC4);
        check_rx("fill");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
